// File: rtl/mips_pipe_pkg.sv
// rtl/mips_pipe_pkg.sv - shared types and constants for the MIPS pipeline hazard logic
package mips_pipe_pkg;

    localparam int DEFAULT_REG_AW = 5;

    localparam logic [DEFAULT_REG_AW-1:0] ZERO_REG = '0;

    typedef struct packed {
        logic                      valid;
        logic [DEFAULT_REG_AW-1:0] dest;
        logic                      reg_write;
        logic                      is_load;
    } sb_entry_t;

endpackage

// File: rtl/hazard_match.sv
// rtl/hazard_match.sv - youngest-writer priority encoder for one source operand
module hazard_match
    import mips_pipe_pkg::*;
#(
    parameter int STAGES           = 3,
    parameter int LOAD_READY_STAGE = 2,
    parameter int FSW              = $clog2(STAGES + 1)
) (
    input  sb_entry_t [STAGES:1]       entries,
    input  logic [DEFAULT_REG_AW-1:0]  src,
    input  logic                       used,
    output logic [FSW-1:0]             fwd_sel,
    output logic                       load_stall
);

    logic [FSW-1:0] hit_k;
    logic           hit_early_load;

    // Walk oldest to youngest so the lowest matching stage is the last one written.
    always_comb begin
        hit_k          = '0;
        hit_early_load = 1'b0;
        for (int k = STAGES; k >= 1; k--) begin
            if (entries[k].valid && entries[k].reg_write && entries[k].dest == src &&
                src != ZERO_REG && used) begin
                hit_k          = FSW'(k);
                hit_early_load = entries[k].is_load && (k < LOAD_READY_STAGE);
            end
        end
        load_stall = hit_early_load;
        fwd_sel    = hit_early_load ? '0 : hit_k;
    end

endmodule

// File: rtl/mips_hazard_scoreboard.sv
// rtl/mips_hazard_scoreboard.sv - stall/flush/forward control from an in-flight writer scoreboard (option: HAZ_PERF_CNT_EN)
module mips_hazard_scoreboard
    import mips_pipe_pkg::*;
#(
    parameter int STAGES           = 3,
    parameter int REG_AW           = mips_pipe_pkg::DEFAULT_REG_AW,
    parameter int BR_STAGE         = 2,
    parameter int LOAD_READY_STAGE = 2,
    parameter int FSW              = $clog2(STAGES + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_rs_used,
    input  logic              id_rt_used,
    input  logic [REG_AW-1:0] id_dest,
    input  logic              id_reg_write,
    input  logic              id_is_load,
    input  logic              branch_taken,
    output logic              stall_if_id,
    output logic              bubble_id_ex,
    output logic [STAGES-1:0] flush_mask,
    output logic [FSW-1:0]    fwd_sel_rs,
    output logic [FSW-1:0]    fwd_sel_rt
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [31:0]       stall_cycles,
    output logic [31:0]       flush_events
`endif
);

    if (BR_STAGE < 1 || BR_STAGE > STAGES) begin : g_bad_br_stage
        $error("BR_STAGE must be within 1..STAGES");
    end
    if (LOAD_READY_STAGE < 1 || LOAD_READY_STAGE > STAGES) begin : g_bad_load_stage
        $error("LOAD_READY_STAGE must be within 1..STAGES");
    end
    if (REG_AW < 1 || REG_AW > DEFAULT_REG_AW) begin : g_bad_reg_aw
        $error("REG_AW must fit the scoreboard entry destination field");
    end

    localparam logic [STAGES-1:0] FLUSH_BITS = STAGES'((64'd1 << BR_STAGE) - 64'd1);

    sb_entry_t [STAGES:1]      entries;
    sb_entry_t                 id_entry;
    logic [FSW-1:0]            sel_rs, sel_rt;
    logic                      ls_rs, ls_rt;
    logic                      flush, stall;

    hazard_match #(.STAGES(STAGES), .LOAD_READY_STAGE(LOAD_READY_STAGE), .FSW(FSW)) u_match_rs (
        .entries    (entries),
        .src        (DEFAULT_REG_AW'(id_rs)),
        .used       (id_rs_used),
        .fwd_sel    (sel_rs),
        .load_stall (ls_rs)
    );

    hazard_match #(.STAGES(STAGES), .LOAD_READY_STAGE(LOAD_READY_STAGE), .FSW(FSW)) u_match_rt (
        .entries    (entries),
        .src        (DEFAULT_REG_AW'(id_rt)),
        .used       (id_rt_used),
        .fwd_sel    (sel_rt),
        .load_stall (ls_rt)
    );

    always_comb begin
        flush        = branch_taken && !rst;
        stall        = id_valid && (ls_rs || ls_rt) && !flush && !rst;
        stall_if_id  = stall;
        bubble_id_ex = stall;
        flush_mask   = flush ? FLUSH_BITS : '0;
        fwd_sel_rs   = rst ? '0 : sel_rs;
        fwd_sel_rt   = rst ? '0 : sel_rt;
        id_entry     = '{valid: 1'b1, dest: DEFAULT_REG_AW'(id_dest),
                         reg_write: id_reg_write, is_load: id_is_load};
    end

    // Stages younger than the branch are squashed as they advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            entries <= '0;
        end else begin
            for (int k = 1; k < STAGES; k++) begin
                entries[k+1] <= (flush && k < BR_STAGE) ? '0 : entries[k];
            end
            entries[1] <= (id_valid && !stall && !flush) ? id_entry : '0;
        end
    end

`ifdef HAZ_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
            flush_events <= '0;
        end else begin
            if (stall && stall_cycles != '1) stall_cycles <= stall_cycles + 32'd1;
            if (flush && flush_events != '1) flush_events <= flush_events + 32'd1;
        end
    end
`endif

endmodule
